vga_plot_sink: RTL and testbench

- Receiving end of the plot interface our drawing FSMs drive (VGA_X, VGA_Y, VGA_COLOUR, VGA_PLOT).
- Captures every plot request and clips it to the 160x120 screen.
- Buffers accepted pixels in a small FIFO and writes them into an external synchronous-read framebuffer RAM.
- Provides a read-back port so benches and later tasks can inspect drawn pixels without the VGA core. Sits beside vga_adapter and snoops the same plot bus.

---
 rtl/vga_plot_sink.sv | 190 +++++++++++++++++++
 tb/tb_vga_plot_sink.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_plot_sink.sv
// Plot-bus snooper: clips plot requests to the screen, queues accepted pixels
// and writes them to an external synchronous-read framebuffer, with a read-back port.
module vga_plot_sink #(
  parameter int unsigned SCREEN_W   = 160,
  parameter int unsigned SCREEN_H   = 120,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic [7:0]  VGA_X,
  input  logic [6:0]  VGA_Y,
  input  logic [2:0]  VGA_COLOUR,
  input  logic        VGA_PLOT,
  output logic        fifo_full,
  output logic        overflow,
  output logic [7:0]  clip_count,
  output logic [15:0] plot_count,
  output logic [14:0] fb_addr,
  output logic [2:0]  fb_wdata,
  output logic        fb_we,
  output logic        fb_re,
  input  logic [2:0]  fb_rdata,
  input  logic        rd_req,
  input  logic [7:0]  rd_x,
  input  logic [6:0]  rd_y,
  output logic        rd_ready,
  output logic        rd_valid,
  output logic [2:0]  rd_colour
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_RD_ISSUE,
    S_RD_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [17:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          fb_we_q, fb_we_d;
  logic          fb_re_q, fb_re_d;
  logic [14:0]   fb_addr_q, fb_addr_d;
  logic [2:0]    fb_wdata_q, fb_wdata_d;
  logic          rd_valid_q, rd_valid_d;
  logic [2:0]    rd_colour_q, rd_colour_d;
  logic          rd_clip_q, rd_clip_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    clip_cnt_q, clip_cnt_d;
  logic [15:0]   plot_cnt_q, plot_cnt_d;

  logic          plot_in_range, rd_in_range;
  logic          full, empty, push, pop;
  logic [17:0]   head;

  // y*160 + x as two shifts and an add; max 19199 fits in 15 bits
  function automatic logic [14:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
    logic [14:0] yy;
    yy = {8'b0, y};
    return (yy << 7) + (yy << 5) + {7'b0, x};
  endfunction

  assign plot_in_range = (32'(VGA_X) < SCREEN_W) && (32'(VGA_Y) < SCREEN_H);
  assign rd_in_range   = (32'(rd_x) < SCREEN_W) && (32'(rd_y) < SCREEN_H);
  assign full          = (count_q == DEPTH_C);
  assign empty         = (count_q == '0);
  // Capture judges fullness on pre-edge occupancy, so a same-edge pop never rescues a push
  assign push          = VGA_PLOT && plot_in_range && !full;
  assign head          = mem_q[rd_ptr_q];

  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {VGA_X, VGA_Y, VGA_COLOUR};
    end
  end

  always_comb begin
    state_d     = state_q;
    fb_we_d     = 1'b0;
    fb_re_d     = 1'b0;
    fb_addr_d   = fb_addr_q;
    fb_wdata_d  = fb_wdata_q;
    rd_valid_d  = 1'b0;
    rd_colour_d = rd_colour_q;
    rd_clip_d   = rd_clip_q;
    plot_cnt_d  = plot_cnt_q;
    pop         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rd_req) begin
          state_d   = S_RD_ISSUE;
          rd_clip_d = !rd_in_range;
          if (rd_in_range) begin
            fb_re_d   = 1'b1;
            fb_addr_d = pix_addr(rd_x, rd_y);
          end
        end else if (!empty) begin
          pop        = 1'b1;
          state_d    = S_WR;
          fb_we_d    = 1'b1;
          fb_addr_d  = pix_addr(head[17:10], head[9:3]);
          fb_wdata_d = head[2:0];
        end
      end
      S_WR: begin
        if (plot_cnt_q != '1) begin
          plot_cnt_d = plot_cnt_q + 16'd1;
        end
        state_d = S_IDLE;
      end
      S_RD_ISSUE: begin
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        rd_colour_d = rd_clip_q ? '0 : fb_rdata;
        rd_valid_d  = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    overflow_d = overflow_q | (VGA_PLOT && plot_in_range && full);
    clip_cnt_d = clip_cnt_q;
    if (VGA_PLOT && !plot_in_range && (clip_cnt_q != '1)) begin
      clip_cnt_d = clip_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fb_we_q     <= 1'b0;
      fb_re_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_wdata_q  <= '0;
      rd_valid_q  <= 1'b0;
      rd_colour_q <= '0;
      rd_clip_q   <= 1'b0;
      overflow_q  <= 1'b0;
      clip_cnt_q  <= '0;
      plot_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fb_we_q     <= fb_we_d;
      fb_re_q     <= fb_re_d;
      fb_addr_q   <= fb_addr_d;
      fb_wdata_q  <= fb_wdata_d;
      rd_valid_q  <= rd_valid_d;
      rd_colour_q <= rd_colour_d;
      rd_clip_q   <= rd_clip_d;
      overflow_q  <= overflow_d;
      clip_cnt_q  <= clip_cnt_d;
      plot_cnt_q  <= plot_cnt_d;
    end
  end

  // Gated by resetn so every output reads 0 while reset is held
  assign rd_ready   = resetn && (state_q == S_IDLE);
  assign fifo_full  = full;
  assign overflow   = overflow_q;
  assign clip_count = clip_cnt_q;
  assign plot_count = plot_cnt_q;
  assign fb_addr    = fb_addr_q;
  assign fb_wdata   = fb_wdata_q;
  assign fb_we      = fb_we_q;
  assign fb_re      = fb_re_q;
  assign rd_valid   = rd_valid_q;
  assign rd_colour  = rd_colour_q;

endmodule

// File: tb/tb_vga_plot_sink.sv
// Bench for vga_plot_sink: queue/schedule model of the sink plus a framebuffer RAM,
// compared against every output on each falling edge.
module tb_vga_plot_sink;

  localparam int DEPTH = 4;

  logic        CLOCK_50   = 1'b0;
  logic        resetn     = 1'b0;
  logic [7:0]  VGA_X      = '0;
  logic [6:0]  VGA_Y      = '0;
  logic [2:0]  VGA_COLOUR = '0;
  logic        VGA_PLOT   = 1'b0;
  logic        rd_req     = 1'b0;
  logic [7:0]  rd_x       = '0;
  logic [6:0]  rd_y       = '0;
  logic [2:0]  fb_rdata;
  logic        fifo_full, overflow, fb_we, fb_re, rd_ready, rd_valid;
  logic [7:0]  clip_count;
  logic [15:0] plot_count;
  logic [14:0] fb_addr;
  logic [2:0]  fb_wdata, rd_colour;

  vga_plot_sink #(.SCREEN_W(160), .SCREEN_H(120), .FIFO_DEPTH(DEPTH)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn),
    .VGA_X(VGA_X), .VGA_Y(VGA_Y), .VGA_COLOUR(VGA_COLOUR), .VGA_PLOT(VGA_PLOT),
    .fifo_full(fifo_full), .overflow(overflow), .clip_count(clip_count), .plot_count(plot_count),
    .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_we(fb_we), .fb_re(fb_re), .fb_rdata(fb_rdata),
    .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_colour(rd_colour)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int want);
    n_checks++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, want, $time);
  endtask

  // Framebuffer RAM: synchronous read, data valid the cycle after fb_re
  logic [2:0] ram [19200];
  logic [2:0] fb_rdata_q = '0;
  assign fb_rdata = fb_rdata_q;
  int tick = 0, n_writes = 0, n_reads = 0;
  int last_waddr = -1, last_wdata = -1, last_raddr = -1, w_tick = -1, r_tick = -1;

  always @(posedge CLOCK_50) begin
    tick++;
    if (fb_we) begin
      if (fb_addr < 15'd19200) ram[fb_addr] = fb_wdata;
      n_writes++;
      last_waddr = int'(fb_addr);
      last_wdata = int'(fb_wdata);
      w_tick = tick;
    end
    if (fb_re) begin
      if (fb_addr < 15'd19200) fb_rdata_q <= ram[fb_addr];
      n_reads++;
      last_raddr = int'(fb_addr);
      r_tick = tick;
    end
  end

  // Model: accepted pixels as a queue; engine occupancy as the edge index at which it is free again
  typedef struct {int x; int y; int c;} pix_t;
  pix_t mq[$];
  logic [2:0] shadow [19200];
  int cyc = 0, free_at = 0, rv_at = -100, pc_at = -100, rv_col = 0, m_acc = 0;
  int e_we = 0, e_re = 0, e_addr = 0, e_wdata = 0, e_valid = 0, e_colour = 0;
  int e_ovf = 0, e_clip = 0, e_plot = 0;

  always @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      mq.delete();
      free_at = 0; rv_at = -100; pc_at = -100;
      e_we = 0; e_re = 0; e_addr = 0; e_wdata = 0; e_valid = 0; e_colour = 0;
      e_ovf = 0; e_clip = 0; e_plot = 0;
    end else begin
      int pre;
      pix_t p;
      cyc++;
      e_we = 0; e_re = 0; e_valid = 0;
      if (cyc == pc_at && e_plot < 65535) e_plot++;
      if (cyc == rv_at) begin e_valid = 1; e_colour = rv_col; end
      pre = mq.size();
      if (free_at <= cyc) begin
        if (rd_req) begin
          if (int'(rd_x) < 160 && int'(rd_y) < 120) begin
            e_re   = 1;
            e_addr = int'(rd_y) * 160 + int'(rd_x);
            rv_col = int'(shadow[e_addr]);
          end else begin
            rv_col = 0;
          end
          rv_at   = cyc + 2;
          free_at = cyc + 3;
        end else if (pre > 0) begin
          p = mq.pop_front();
          e_we    = 1;
          e_addr  = p.y * 160 + p.x;
          e_wdata = p.c;
          shadow[e_addr] = 3'(p.c);
          pc_at   = cyc + 1;
          free_at = cyc + 2;
        end
      end
      if (VGA_PLOT) begin
        if (int'(VGA_X) >= 160 || int'(VGA_Y) >= 120) begin
          if (e_clip < 255) e_clip++;
        end else if (pre == DEPTH) begin
          e_ovf = 1;
        end else begin
          p.x = int'(VGA_X); p.y = int'(VGA_Y); p.c = int'(VGA_COLOUR);
          mq.push_back(p);
          m_acc++;
        end
      end
    end
  end

  bit chk_en = 0;
  bit seen_full = 0;
  int acc_tick = -1, val_tick = -1, n_valid = 0, last_rcol = -1;

  always @(negedge CLOCK_50) begin
    if (chk_en) begin
      chk("fb_we", int'(fb_we), e_we);
      chk("fb_re", int'(fb_re), e_re);
      chk("fb_we_re_excl", int'(fb_we & fb_re), 0);
      chk("fb_addr", int'(fb_addr), e_addr);
      chk("fb_wdata", int'(fb_wdata), e_wdata);
      chk("rd_valid", int'(rd_valid), e_valid);
      chk("rd_colour", int'(rd_colour), e_colour);
      chk("rd_ready", int'(rd_ready), (resetn && free_at <= cyc + 1) ? 1 : 0);
      chk("fifo_full", int'(fifo_full), (resetn && mq.size() == DEPTH) ? 1 : 0);
      chk("overflow", int'(overflow), e_ovf);
      chk("clip_count", int'(clip_count), e_clip);
      chk("plot_count", int'(plot_count), e_plot);
    end
    if (fifo_full) seen_full = 1;
    if (rd_req && rd_ready) acc_tick = tick;
    if (rd_valid) begin
      n_valid++;
      val_tick  = tick;
      last_rcol = int'(rd_colour);
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge CLOCK_50); #2; end
  endtask

  task automatic plot(input int x, input int y, input int c);
    VGA_X = 8'(x); VGA_Y = 7'(y); VGA_COLOUR = 3'(c); VGA_PLOT = 1'b1;
    step(1);
    VGA_PLOT = 1'b0;
  endtask

  task automatic read(input int x, input int y);
    bit got;
    got = 0;
    rd_req = 1'b1; rd_x = 8'(x); rd_y = 7'(y);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLOCK_50);
      got = rd_ready;
      @(posedge CLOCK_50); #2;
    end
    rd_req = 1'b0;
    if (!got) chk("rd_accept_timeout", 0, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    int w, acc0, nr, nv;
    step(2);
    chk_en = 1;
    step(1);
    resetn = 1'b1;
    step(2);
    chk("rst_plot_count", int'(plot_count), 0);
    chk("rst_clip_count", int'(clip_count), 0);

    // Single pixel
    plot(10, 5, 2);
    step(4);
    chk("t1_addr", last_waddr, 810);
    chk("t1_data", last_wdata, 2);
    chk("t1_plot_count", int'(plot_count), 1);
    chk("t1_overflow", int'(overflow), 0);

    // Corner pixel then two clipped plots
    w = n_writes;
    plot(159, 119, 7);
    plot(160, 0, 1);
    plot(0, 120, 1);
    step(4);
    chk("t2_writes", n_writes - w, 1);
    chk("t2_addr", last_waddr, 19199);
    chk("t2_clip_count", int'(clip_count), 2);

    // Burst of eight in-range plots overruns the FIFO
    w = n_writes; acc0 = m_acc; seen_full = 0;
    for (int i = 0; i < 8; i++) begin
      VGA_X = 8'(10 + 3 * i); VGA_Y = 7'd60; VGA_COLOUR = 3'(i); VGA_PLOT = 1'b1;
      step(1);
    end
    VGA_PLOT = 1'b0;
    step(20);
    chk("t3_full_seen", int'(seen_full), 1);
    chk("t3_overflow", int'(overflow), 1);
    chk("t3_writes", n_writes - w, m_acc - acc0);
    chk("t3_dropped_some", (m_acc - acc0 < 8) ? 1 : 0, 1);

    // Write then read back, then an out-of-range read
    plot(20, 30, 5);
    step(4);
    read(20, 30);
    step(5);
    chk("t4_raddr", last_raddr, 4820);
    chk("t4_latency", val_tick - acc_tick, 3);
    chk("t4_colour", last_rcol, 5);
    nr = n_reads; nv = n_valid;
    read(200, 3);
    step(5);
    chk("t4_clip_no_re", n_reads - nr, 0);
    chk("t4_clip_valid", n_valid - nv, 1);
    chk("t4_clip_latency", val_tick - acc_tick, 3);
    chk("t4_clip_colour", last_rcol, 0);

    // Read and plot on the same edge: read served first
    VGA_X = 8'd30; VGA_Y = 7'd40; VGA_COLOUR = 3'd6; VGA_PLOT = 1'b1;
    read(20, 30);
    VGA_PLOT = 1'b0;
    step(8);
    chk("t5_read_first", (r_tick > 0 && r_tick < w_tick) ? 1 : 0, 1);
    chk("t5_colour", last_rcol, 5);
    chk("t5_waddr", last_waddr, 6430);
    chk("t5_wdata", last_wdata, 6);

    // Reset while waiting for read data
    nv = n_valid;
    read(20, 30);
    step(1);
    resetn = 1'b0;
    #1;
    chk("t6_rst_rd_ready", int'(rd_ready), 0);
    chk("t6_rst_overflow", int'(overflow), 0);
    step(2);
    resetn = 1'b1;
    step(5);
    chk("t6_no_valid", n_valid - nv, 0);

    // Reset while a write is on the bus and another pixel is queued
    plot(1, 1, 1);
    plot(2, 2, 2);
    w = n_writes;
    chk("t6_we_before_rst", int'(fb_we), 1);
    resetn = 1'b0;
    step(2);
    resetn = 1'b1;
    step(6);
    chk("t6_no_write", n_writes - w, 0);
    chk("t6_fifo_full", int'(fifo_full), 0);
    chk("t6_plot_count", int'(plot_count), 0);
    chk("t6_clip_count", int'(clip_count), 0);
    chk("t6_overflow", int'(overflow), 0);

    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
